// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the two-master data memory arbiter:
//   - DMEM_XLEN           : default data/address width
//   - MAX_BURST_DEFAULT   : default bound on consecutive locked grants
//   - arb_state_e         : lock FSM state encoding
//   - lock_mask()         : which masters the current lock state shuts out
//   - bcnt_next()         : burst count a grant to a given master would produce
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int DMEM_XLEN         = 32;
  localparam int MAX_BURST_DEFAULT = 8;

  typedef enum logic [1:0] {
    ARB_UNLOCKED = 2'b00,
    ARB_LOCK0    = 2'b01,
    ARB_LOCK1    = 2'b10
  } arb_state_e;

  // Mask bit N set means master N may not be granted this cycle. A lock only
  // shuts out the other master while the lock owner is still requesting; once
  // the owner drops its request the other master may be served the same cycle.
  function automatic logic [1:0] lock_mask(input arb_state_e st,
                                           input logic       m0_req,
                                           input logic       m1_req);
    logic [1:0] mask;
    mask = 2'b00;
    case (st)
      ARB_LOCK0: mask = m0_req ? 2'b10 : 2'b00;
      ARB_LOCK1: mask = m1_req ? 2'b01 : 2'b00;
      default:   mask = 2'b00;
    endcase
    return mask;
  endfunction

  // Burst count after a grant to a master: continues the count when that
  // master already holds the lock, otherwise a fresh burst starts at 1.
  function automatic logic [7:0] bcnt_next(input logic       owner_locked,
                                           input logic [7:0] bcnt);
    logic [7:0] nxt;
    if (owner_locked) begin
      nxt = bcnt + 8'd1;
    end else begin
      nxt = 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-input round-robin picker, purely combinational.
// Ports:
//   req  [1:0] in  : raw requests, bit N = master N
//   last       in  : master granted most recently
//   mask [1:0] in  : bit N set excludes master N from this pick
//   gnt  [1:0] out : one-hot (or zero) grant
// On a tie between unmasked requesters the master that is not 'last' wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] w_req;

  assign w_req = req & ~mask;

  // Priority decode of the eligible requests
  always_comb begin
    gnt = 2'b00;
    case (w_req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory port between master 0 (datapath) and master 1
// (loader / debug). Round-robin arbitration with an optional bounded lock for
// bursts; read data returns one cycle later tagged to the issuing master.
// Parameters:
//   XLEN      : data/address width
//   MAX_BURST : max consecutive locked grants to one master (>= 1)
// Ports:
//   clk, reset          : clock, async active-low reset
//   mN_req/we/lock      : request, write(1)/read(0), hold priority next cycle
//   mN_addr/mN_wdata    : byte address, write data
//   mN_gnt              : access accepted this cycle (combinational)
//   mN_rvalid/mN_rdata  : registered read valid, read data (0 when not valid)
//   mem_addr/wdata/we/re: memory port, all zero with no grant
//   mem_rdata           : memory read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN      = DMEM_XLEN,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic            m0_lock,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST);

  arb_state_e      r_state;
  logic [BW-1:0]   r_bcnt;
  logic            r_last;
  // One-hot read return: bit N set means master N issued a read last cycle.
  // This carries the read tag and the pending strobe in a single register.
  logic [1:0]      r_rvalid;

  logic [1:0]      w_mask;
  logic [1:0]      w_pick;
  logic [1:0]      w_gnt;
  logic [BW-1:0]   w_bnext0;
  logic [BW-1:0]   w_bnext1;
  logic [7:0]      w_bcnt_ext;
  logic            w_mem_we;
  logic            w_mem_re;
  logic [XLEN-1:0] w_mem_addr;
  logic [XLEN-1:0] w_mem_wdata;

  assign w_mask = lock_mask(r_state, m0_req, m1_req);

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (r_last),
    .mask (w_mask),
    .gnt  (w_pick)
  );

  // Grants are forced low for as long as reset is held.
  assign w_gnt  = w_pick & {2{reset}};
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  assign w_bcnt_ext = 8'(r_bcnt);
  assign w_bnext0   = BW'(bcnt_next(r_state == ARB_LOCK0, w_bcnt_ext));
  assign w_bnext1   = BW'(bcnt_next(r_state == ARB_LOCK1, w_bcnt_ext));

  // Route the granted master onto the memory port; idle port drives zeros
  always_comb begin
    w_mem_addr  = {XLEN{1'b0}};
    w_mem_wdata = {XLEN{1'b0}};
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    if (w_gnt[0]) begin
      w_mem_addr  = m0_addr;
      w_mem_wdata = m0_wdata;
      w_mem_we    = m0_we;
      w_mem_re    = ~m0_we;
    end else if (w_gnt[1]) begin
      w_mem_addr  = m1_addr;
      w_mem_wdata = m1_wdata;
      w_mem_we    = m1_we;
      w_mem_re    = ~m1_we;
    end else begin
      w_mem_addr  = {XLEN{1'b0}};
      w_mem_wdata = {XLEN{1'b0}};
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
    end
  end

  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign mem_we    = w_mem_we;
  assign mem_re    = w_mem_re;

  // Lock FSM, round-robin history and read-return tag.
  // A grant whose burst count would reach MAX_BURST is the final grant of the
  // burst: its lock request is ignored, so the next cycle arbitrates unlocked
  // with last = owner and the other master wins if it is waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ARB_UNLOCKED;
      r_bcnt   <= {BW{1'b0}};
      r_last   <= 1'b1;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= w_gnt & {2{w_mem_re}};
      if (w_gnt[0]) begin
        r_last <= 1'b0;
        if (m0_lock && (w_bnext0 != BCNT_MAX)) begin
          r_state <= ARB_LOCK0;
          r_bcnt  <= w_bnext0;
        end else begin
          r_state <= ARB_UNLOCKED;
          r_bcnt  <= {BW{1'b0}};
        end
      end else if (w_gnt[1]) begin
        r_last <= 1'b1;
        if (m1_lock && (w_bnext1 != BCNT_MAX)) begin
          r_state <= ARB_LOCK1;
          r_bcnt  <= w_bnext1;
        end else begin
          r_state <= ARB_UNLOCKED;
          r_bcnt  <= {BW{1'b0}};
        end
      end else begin
        // No grant: either nobody asked, or the lock owner dropped its request.
        r_last  <= r_last;
        r_state <= ARB_UNLOCKED;
        r_bcnt  <= {BW{1'b0}};
      end
    end
  end

  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];

  // Read data is only presented to the master that owns the returning read
  always_comb begin
    m0_rdata = {XLEN{1'b0}};
    m1_rdata = {XLEN{1'b0}};
    if (r_rvalid[0]) begin
      m0_rdata = mem_rdata;
    end else begin
      m0_rdata = {XLEN{1'b0}};
    end
    if (r_rvalid[1]) begin
      m1_rdata = mem_rdata;
    end else begin
      m1_rdata = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Table-driven bench for dmem_arbiter (XLEN 32, MAX_BURST 8) with a small
// memory stub. Each table row is one clock cycle: inputs applied just after
// the rising edge, outputs compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0000_0100;
  localparam logic [31:0] A2 = 32'h0000_0200;
  localparam logic [31:0] AW = 32'h0000_0040;
  localparam logic [31:0] D1 = 32'hA500_0100;
  localparam logic [31:0] D2 = 32'hA500_0200;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        g0, g1, mwe, mre;
    logic [31:0] maddr, mwd;
    logic        v0, v1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vq[$];

  dmem_arbiter #(.XLEN(32), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: word at byte address a holds 0xA5000000 | a until written;
  // read data appears the cycle after mem_re.
  logic [31:0] mem [0:255];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | (32'(i) << 2);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic rst,
      input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
      input logic g0, input logic g1, input logic mwe, input logic mre,
      input logic [31:0] maddr, input logic [31:0] mwd,
      input logic v0, input logic v1, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.mre = mre; v.maddr = maddr; v.mwd = mwd;
    v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = Z; m0_wdata = Z;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = Z; m1_wdata = Z;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    idle_inputs();

    // reset hold: both requesting, nothing granted
    vq.push_back(mk(0, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,0,0,0,Z,Z, 0,0,Z,Z));
    vq.push_back(mk(0, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,0,0,0,Z,Z, 0,0,Z,Z));
    // tie after reset: alternate m0, m1 with tagged read return
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 1,0,0,1,A1,Z, 0,0,Z,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,1,0,1,A2,Z, 1,0,D1,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 1,0,0,1,A1,Z, 0,1,Z,D2));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,1,0,1,A2,Z, 1,0,D1,Z));
    // mixed write/read: m0 writes 0x40, m1 reads it back
    vq.push_back(mk(1, 1,1,0,AW,DW, 0,0,0,Z,Z, 1,0,1,0,AW,DW, 0,1,Z,D2));
    vq.push_back(mk(1, 0,0,0,Z,Z, 1,0,0,AW,Z, 0,1,0,1,AW,Z, 0,0,Z,Z));
    vq.push_back(mk(1, 0,0,0,Z,Z, 0,0,0,Z,Z, 0,0,0,0,Z,Z, 0,1,Z,DW));
    vq.push_back(mk(1, 0,0,0,Z,Z, 0,0,0,Z,Z, 0,0,0,0,Z,Z, 0,0,Z,Z));
    // locked burst: m0 wins the tie, then m1 holds 8 grants, then m0
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 1,0,0,1,A1,Z, 0,0,Z,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 0,1,0,1,A2,Z, 1,0,D1,Z));
    for (int k = 0; k < 7; k++)
      vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 0,1,0,1,A2,Z, 0,1,Z,D2));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 1,0,0,1,A1,Z, 0,1,Z,D2));
    // lock release: m1 locks, then drops req on its third cycle
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 0,1,0,1,A2,Z, 1,0,D1,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,1,A2,Z, 0,1,0,1,A2,Z, 0,1,Z,D2));
    vq.push_back(mk(1, 1,0,0,A1,Z, 0,0,1,A2,Z, 1,0,0,1,A1,Z, 0,1,Z,D2));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,1,0,1,A2,Z, 1,0,D1,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 1,0,0,1,A1,Z, 0,1,Z,D2));
    // reset mid-read: m0 read, reset next cycle drops its rvalid
    vq.push_back(mk(1, 1,0,0,A1,Z, 0,0,0,Z,Z, 1,0,0,1,A1,Z, 1,0,D1,Z));
    vq.push_back(mk(0, 1,0,0,A1,Z, 1,0,0,A2,Z, 0,0,0,0,Z,Z, 0,0,Z,Z));
    vq.push_back(mk(1, 1,0,0,A1,Z, 1,0,0,A2,Z, 1,0,0,1,A1,Z, 0,0,Z,Z));
    vq.push_back(mk(1, 0,0,0,Z,Z, 0,0,0,Z,Z, 0,0,0,0,Z,Z, 1,0,D1,Z));

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset   = vq[i].rst;
      m0_req  = vq[i].r0; m0_we = vq[i].w0; m0_lock = vq[i].l0;
      m0_addr = vq[i].a0; m0_wdata = vq[i].d0;
      m1_req  = vq[i].r1; m1_we = vq[i].w1; m1_lock = vq[i].l1;
      m1_addr = vq[i].a1; m1_wdata = vq[i].d1;
      @(negedge clk);
      chk($sformatf("row%0d m0_gnt", i),    {31'b0, m0_gnt},    {31'b0, vq[i].g0});
      chk($sformatf("row%0d m1_gnt", i),    {31'b0, m1_gnt},    {31'b0, vq[i].g1});
      chk($sformatf("row%0d mem_we", i),    {31'b0, mem_we},    {31'b0, vq[i].mwe});
      chk($sformatf("row%0d mem_re", i),    {31'b0, mem_re},    {31'b0, vq[i].mre});
      chk($sformatf("row%0d mem_addr", i),  mem_addr,           vq[i].maddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,          vq[i].mwd);
      chk($sformatf("row%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, vq[i].v0});
      chk($sformatf("row%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, vq[i].v1});
      chk($sformatf("row%0d m0_rdata", i),  m0_rdata,           vq[i].rd0);
      chk($sformatf("row%0d m1_rdata", i),  m1_rdata,           vq[i].rd1);
    end

    // Asynchronous reset while a read return is pending and m1 is requesting
    @(posedge clk);
    #1;
    idle_inputs();
    m0_req = 1'b1; m0_addr = A1;
    @(negedge clk);
    chk("seq m0_gnt single", {31'b0, m0_gnt}, 32'd1);
    @(posedge clk);
    #1;
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = A2;
    #1;
    chk("seq m0_rvalid before reset", {31'b0, m0_rvalid}, 32'd1);
    chk("seq m0_rdata before reset", m0_rdata, D1);
    chk("seq m1_gnt before reset", {31'b0, m1_gnt}, 32'd1);
    reset = 1'b0;
    #1;
    chk("seq m0_rvalid async drop", {31'b0, m0_rvalid}, 32'd0);
    chk("seq m0_rdata async drop", m0_rdata, Z);
    chk("seq m1_gnt in reset", {31'b0, m1_gnt}, 32'd0);
    chk("seq mem_re in reset", {31'b0, mem_re}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = A1;
    @(negedge clk);
    chk("seq tie after reset m0", {31'b0, m0_gnt}, 32'd1);
    chk("seq tie after reset m1", {31'b0, m1_gnt}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("seq m0_rvalid after reset", {31'b0, m0_rvalid}, 32'd1);
    chk("seq m0_rdata after reset", m0_rdata, D1);
    chk("seq m1_rvalid after reset", {31'b0, m1_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data memory port between the datapath (master 0) and a second requester such as a program loader or debug port (master 1). Sits between the requesters and `dmem`/console decode in `bbq`. Arbitration is round-robin with an optional bounded lock for bursts. Read data returns with a one-cycle registered valid tagged to the master that issued the read.

## Interface
- `XLEN`, from `constants.vh`: data/address width.
- `MAX_BURST`, default 8: maximum consecutive locked grants to one master before the lock is overridden (≥1).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; asserted when 0.
- `m0_req` / `m1_req` in 1: access request.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_lock` / `m1_lock` in 1: request priority for the next cycle.
- `m0_addr` / `m1_addr` in XLEN: byte address.
- `m0_wdata` / `m1_wdata` in XLEN: write data.
- `m0_gnt` / `m1_gnt` out 1: access accepted this cycle (combinational).
- `m0_rvalid` / `m1_rvalid` out 1: read data valid, registered.
- `m0_rdata` / `m1_rdata` out XLEN: read data.
- `mem_addr` out XLEN: address to memory.
- `mem_wdata` out XLEN: write data to memory.
- `mem_we` out 1: write enable to memory.
- `mem_re` out 1: read strobe to memory.
- `mem_rdata` in XLEN: memory read data, valid the cycle after `mem_re`.

## Operation
- Grants:
  - At most one `mN_gnt` per cycle.
  - A grant requires `mN_req` = 1.
  - A granted access is complete from the master's view. The master may change `req`/`addr` next cycle.
- Arbitration state `last` (1 bit, reset 1) records the last granted master.
  - With both masters requesting and no lock active, grant the master ≠ `last`.
  - With a single requester, grant it.
  - Result: master 0 wins the first tie after reset.
- Lock FSM:
  - States `UNLOCKED`, `LOCK0`, `LOCK1` (reset `UNLOCKED`), with a burst counter `bcnt` (reset 0, width clog2(MAX_BURST+1)).
  - Grant to master N with `mN_lock` = 1: next state `LOCKN`. `bcnt` = 1 if entering from a different state, else `bcnt` + 1.
  - In `LOCKN`, only master N may be granted; the other master's request waits.
  - Exit `LOCKN` to `UNLOCKED` in any of these cases:
    - master N is granted with `mN_lock` = 0;
    - `mN_req` = 0 (no grant that cycle; the other master may be granted in the same cycle);
    - `bcnt` == MAX_BURST at a grant. That grant is still made, and the next cycle arbitrates unlocked with `last` = N, so the other master wins if requesting.
  - Any unlocked grant clears `bcnt` to 0 unless it enters a lock.
- Memory drive:
  - The granted master's `addr`/`wdata` pass through.
  - `mem_we` = gnt & we; `mem_re` = gnt & ~we.
  - With no grant, `mem_addr`/`mem_wdata` = 0 and `mem_we`/`mem_re` = 0.
- Read return:
  - `rtag` (reset 0) and `rpend` (reset 0) register the master and read strobe.
  - Next cycle, `m{rtag}_rvalid` = `rpend`.
  - `mN_rdata` = `mem_rdata` when `mN_rvalid`, else 0.
- Writes produce no `rvalid`.

## Timing
- Grant and memory strobes: same cycle as `req`, combinational from `req`, `we`, `lock` and registered state. No combinational path from `mem_rdata` to the grant logic.
- Read latency: `rvalid` is exactly 1 cycle after the granted read. Back-to-back reads from either master give `rvalid` every cycle, correctly tagged.
- Reset values:
  - `rvalid` 0, `rdata` 0.
  - `gnt` 0 while `reset` = 0. All grants are forced low during reset regardless of `req`.
  - `mem_we`/`mem_re` 0.
  - FSM `UNLOCKED`, `bcnt` 0, `last` 1.
- Reset mid-burst or with a read pending: the pending `rvalid` is dropped and the lock is released asynchronously.
- A lock request on the final (MAX_BURST-th) grant is ignored.
- With MAX_BURST = 1, locks never delay the other master.

## Structure
- FSM state encoding (`ARB_UNLOCKED`, `ARB_LOCK0`, `ARB_LOCK1`) goes in `constants.vh` next to the XLEN macros.
- Single module. A sub-module `rr_pick2` (two-input round-robin picker, combinational, inputs `req[1:0]`, `last`, `mask`) keeps the lock logic separate.
- `bbq` instantiates `dmem_arbiter` between `datapath` and the console/dmem decode. The decode is unchanged and now driven from `mem_*`.

## Test plan
- **Reset hold:** `reset` = 0 with `m0_req` = `m1_req` = 1 → both `gnt` 0, `mem_we`/`mem_re` 0.
- **Tie after reset:** release reset, both masters read at 0x100/0x200 every cycle → grants alternate m0, m1, m0, … Each `rvalid` is 1 cycle later on the matching master with memory data for that address.
- **Locked burst:** `m1_lock` = 1, `m1_req` held, `m0_req` held, MAX_BURST = 8 → m1 granted 8 consecutive cycles, then m0 granted on cycle 9.
- **Lock release:** m1 locked, drops `m1_req` at cycle 3 → m0 granted that same cycle; FSM `UNLOCKED`.
- **Mixed write/read:** m0 writes 0xDEADBEEF to 0x40, m1 reads 0x40 the next cycle → `m1_rdata` = 0xDEADBEEF with `m1_rvalid` one cycle later; `m0_rvalid` never set.
- **Reset mid-read:** assert reset in the cycle after a granted m0 read → `m0_rvalid` stays 0; after release the first tie goes to m0.
